// File: rtl/ex_div_unit_pkg.sv
// Shared divider constants and state encoding.
// Result width sits with the other EX-to-MEM bus width defines.
`ifndef EX_DIV_BUS_DEFINES
`define EX_DIV_BUS_DEFINES
`define EX_DIV_RES_W 64
`endif

package ex_div_unit_pkg;

    localparam int DIV_DW    = 32;
    localparam int DIV_CNT_W = 6;
    localparam int DIV_RES_W = `EX_DIV_RES_W;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_BUSY   = 2'd2,
        DIV_DONE   = 2'd3
    } div_state_e;

endpackage

// File: rtl/ex_div_unit_if.sv
// EX <-> divider handshake: request held until ready, result {rem, quot}.
// No backpressure beyond the start/ready hold protocol.
interface ex_div_unit_if
    import ex_div_unit_pkg::*;
#(
    parameter int DW = DIV_DW
);
    logic              div_start;
    logic              div_signed;
    logic [DW-1:0]     div_opdata1;
    logic [DW-1:0]     div_opdata2;
    logic              div_annul;
    logic [2*DW-1:0]   div_result;
    logic              div_ready;
    logic              stallreq_for_div;

    modport master (
        output div_start, div_signed, div_opdata1, div_opdata2, div_annul,
        input  div_result, div_ready, stallreq_for_div
    );

    modport slave (
        input  div_start, div_signed, div_opdata1, div_opdata2, div_annul,
        output div_result, div_ready, stallreq_for_div
    );
endinterface

// File: rtl/ex_div_unit_div_restore_step.sv
// One restoring-division iteration; purely combinational, zero latency.
// No flow control: the caller decides when to register the outputs.
module div_restore_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rem_i,
    input  logic          dvd_msb_i,
    input  logic [DW-1:0] divisor_i,
    output logic [DW-1:0] rem_o,
    output logic          q_bit_o
);
    logic [DW:0] shifted;
    logic [DW:0] trial;

    assign shifted = {rem_i, dvd_msb_i};
    assign trial   = shifted - {1'b0, divisor_i};

    // rem_i < divisor keeps shifted below 2*divisor, so the sign bit is exact.
    assign q_bit_o = ~trial[DW];
    assign rem_o   = q_bit_o ? trial[DW-1:0] : shifted[DW-1:0];
endmodule

// File: rtl/ex_div_unit.sv
// 32-bit radix-2 restoring DIV/DIVU; result DW+1 edges after acceptance (2 for /0).
// EX holds div_start until div_ready; stallreq_for_div freezes the pipe meanwhile.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int DW    = DIV_DW,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    ex_div_unit_if.slave  div_if
);
    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     rem_q, rem_d;
    logic [DW-1:0]     dvd_q, dvd_d;
    logic [DW-1:0]     dvs_q, dvs_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic [2*DW-1:0]   result_q, result_d;
    logic              ready_q, ready_d;

    logic [DW-1:0]     step_rem;
    logic              step_qbit;
    logic [DW-1:0]     quot_raw;
    logic              op1_neg, op2_neg;
    logic [DW-1:0]     op1_mag, op2_mag;

    div_restore_step #(.DW(DW)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[DW-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    // Quotient bits shift into the vacated low end of the dividend register.
    assign quot_raw = {dvd_q[DW-2:0], step_qbit};

    assign op1_neg = div_if.div_signed & div_if.div_opdata1[DW-1];
    assign op2_neg = div_if.div_signed & div_if.div_opdata2[DW-1];
    assign op1_mag = op1_neg ? -div_if.div_opdata1 : div_if.div_opdata1;
    assign op2_mag = op2_neg ? -div_if.div_opdata2 : div_if.div_opdata2;

    assign div_if.div_result       = result_q;
    assign div_if.div_ready        = ready_q;
    assign div_if.stallreq_for_div = div_if.div_start & ~ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        ready_d  = ready_q;

        unique case (state_q)
            DIV_IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (div_if.div_start && !div_if.div_annul) begin
                    if (div_if.div_opdata2 == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d = DIV_BUSY;
                        dvd_d   = op1_mag;
                        dvs_d   = op2_mag;
                        q_neg_d = op1_neg ^ op2_neg;
                        r_neg_d = op1_neg;
                        rem_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            DIV_BYZERO: begin
                if (div_if.div_annul) begin
                    state_d  = DIV_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    state_d  = DIV_DONE;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
            end
            DIV_BUSY: begin
                if (div_if.div_annul) begin
                    state_d  = DIV_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    rem_d = step_rem;
                    dvd_d = quot_raw;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DW - 1)) begin
                        state_d  = DIV_DONE;
                        ready_d  = 1'b1;
                        result_d = {(r_neg_q ? -step_rem : step_rem),
                                    (q_neg_q ? -quot_raw : quot_raw)};
                    end
                end
            end
            DIV_DONE: begin
                if (div_if.div_annul || !div_if.div_start) begin
                    state_d  = DIV_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = DIV_IDLE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end
endmodule

// File: tb/tb_ex_div_unit.sv
// Directed plus random checks of ex_div_unit against a plain-arithmetic model.
module tb_ex_div_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    ex_div_unit_if dif ();

    ex_div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sign/magnitude long division as the ISA defines it; /0 yields 0.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        bit na, nb;
        if (b == 32'd0) return 64'd0;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? 32'(0 - a) : a;
        mb = nb ? 32'(0 - b) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (na ^ nb) q = 32'(0 - q);
        if (na)      r = 32'(0 - r);
        return {r, q};
    endfunction

    task automatic wait_ready(output int edges, inout int stalls);
        edges = 0;
        while (edges < 40) begin
            @(negedge clk);
            edges++;
            if (dif.div_ready) break;
            if (dif.stallreq_for_div) stalls++;
        end
    endtask

    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int exp_lat, input string tag);
        int edges;
        int stalls;
        dif.div_signed  = sgn;
        dif.div_opdata1 = a;
        dif.div_opdata2 = b;
        dif.div_start   = 1'b1;
        #1;
        stalls = dif.stallreq_for_div ? 1 : 0;
        wait_ready(edges, stalls);
        chk({tag, "_lat"}, 64'(edges), 64'(exp_lat));
        chk({tag, "_res"}, dif.div_result, exp);
        chk({tag, "_stallcyc"}, 64'(stalls), 64'(exp_lat));
        chk({tag, "_stall_off"}, 64'(dif.stallreq_for_div), 64'd0);
        dif.div_start = 1'b0;
        @(negedge clk);
        chk({tag, "_drop"}, {dif.div_result[62:0], dif.div_ready}, 64'd0);
    endtask

    initial begin
        int edges;
        int stalls;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        dif.div_start   = 1'b0;
        dif.div_signed  = 1'b0;
        dif.div_opdata1 = '0;
        dif.div_opdata2 = '0;
        dif.div_annul   = 1'b0;
        #1;
        chk("reset_ready", 64'(dif.div_ready), 64'd0);
        chk("reset_result", dif.div_result, 64'd0);
        chk("reset_stall", 64'(dif.stallreq_for_div), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "udiv_100_7");
        run_div(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "sdiv_m7_2");
        run_div(1'b1, 32'h7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 33, "sdiv_7_m2");
        run_div(1'b0, 32'd5, 32'd0, 64'd0, 2, "div_by_zero");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, "sdiv_ovf");
        run_div(1'b0, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF}, 33, "udiv_max_1");

        // Annul on the 10th BUSY cycle, then a fresh 9/3 whose operands get disturbed.
        dif.div_signed  = 1'b0;
        dif.div_opdata1 = 32'd1000;
        dif.div_opdata2 = 32'd3;
        dif.div_start   = 1'b1;
        @(negedge clk);
        repeat (9) @(negedge clk);
        dif.div_annul   = 1'b1;
        dif.div_opdata1 = 32'd9;
        dif.div_opdata2 = 32'd3;
        @(negedge clk);
        chk("annul_ready", 64'(dif.div_ready), 64'd0);
        chk("annul_result", dif.div_result, 64'd0);
        dif.div_annul = 1'b0;
        stalls = 0;
        edges  = 0;
        while (edges < 40) begin
            @(negedge clk);
            edges++;
            if (edges == 5) begin
                dif.div_opdata1 = 32'hDEADBEEF;
                dif.div_opdata2 = 32'h00000000;
                dif.div_signed  = 1'b1;
            end
            if (dif.div_ready) break;
        end
        chk("after_annul_lat", 64'(edges), 64'd33);
        chk("after_annul_res", dif.div_result, {32'd0, 32'd3});
        dif.div_start = 1'b0;
        @(negedge clk);

        // Async reset between edges, mid-BUSY and again while DONE holds a result.
        dif.div_signed  = 1'b0;
        dif.div_opdata1 = 32'd100;
        dif.div_opdata2 = 32'd7;
        dif.div_start   = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_busy_ready", 64'(dif.div_ready), 64'd0);
        chk("rst_busy_result", dif.div_result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        stalls = 0;
        wait_ready(edges, stalls);
        chk("rst_rerun_lat", 64'(edges), 64'd33);
        chk("rst_rerun_res", dif.div_result, {32'd2, 32'd14});
        #2 rst = 1'b0;
        #1;
        chk("rst_done_ready", 64'(dif.div_ready), 64'd0);
        chk("rst_done_result", dif.div_result, 64'd0);
        @(negedge clk);
        dif.div_start = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            bit sgn;
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 5) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 4))
                0:       b = 32'($urandom_range(1, 15));
                1:       b = 32'd0;
                2:       b = 32'hFFFFFFFF;
                3:       b = 32'($urandom) >> $urandom_range(0, 31);
                default: b = 32'($urandom);
            endcase
            run_div(sgn, a, b, model(sgn, a, b), (b == 32'd0) ? 2 : 33,
                    $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
Iterative 32-bit radix-2 restoring divider in the EX stage; serves DIV/DIVU.
- EX holds a request until the result is ready, stalling the pipeline through stallreq_for_div.
- EX places the remainder/quotient into the hi/lo fields of the EX-to-MEM bus with hi_we/lo_we set, and that bus feeds MEM.
- One divide in flight; operands captured at acceptance.

Parameters:
DW, 32, operand width; quotient and remainder are DW bits each, result is 2*DW.
CNT_W, 6, step-counter width; must hold values 0..DW.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (0 = reset)
div_start  in  1  request; held by EX until div_ready seen
div_signed  in  1  1 = DIV (two's complement), 0 = DIVU
div_opdata1  in  DW  dividend
div_opdata2  in  DW  divisor
div_annul  in  1  abort current operation (exception/flush)
div_result  out  2*DW  {remainder (hi), quotient (lo)}
div_ready  out  1  div_result valid
stallreq_for_div  out  1  pipeline stall request

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, div_result=0, div_ready=0; no clock edge needed.
- stallreq_for_div = div_start & ~div_ready (combinational).
- States: IDLE, BYZERO, BUSY, DONE; div_result/div_ready registered.
- IDLE:
  - div_start=1, div_annul=0, divisor==0 -> BYZERO.
  - div_start=1, div_annul=0, divisor!=0 -> BUSY. Capture |dividend| and |divisor| (magnitudes only if div_signed), the quotient sign (sign1^sign2) and the remainder sign (sign1); partial remainder=0, counter=0.
  - Otherwise stay; div_ready=0, div_result=0.
- BYZERO: next edge -> DONE, div_result=0, div_ready=1.
- BUSY, one step per edge:
  - Trial = {rem[DW-1:0], dvd_msb} - {1'b0, divisor}, DW+1 bits.
  - Trial non-negative: rem=trial, quotient bit=1. Else rem keeps the shifted value, bit=0.
  - Dividend shifts left; counter+1.
  - The edge completing step DW-1 (counter==DW-1) applies the sign fix-up: negate quotient if quotient-sign set, negate remainder if remainder-sign set. It then loads div_result, sets div_ready=1 and goes -> DONE.
- DONE:
  - Hold result and ready while div_start=1.
  - div_start=0 -> IDLE; div_ready=0, div_result=0 on that edge.
- Latency, with acceptance edge E: ready visible after E+DW (33 edges total including E); BYZERO ready after 2 edges.
- div_annul=1 in BYZERO/BUSY/DONE -> IDLE next edge, ready=0, result=0; annul beats completion on the same edge.
- Operand or div_signed changes after acceptance are ignored.
- New request accepted only from IDLE; back-to-back divides need one IDLE cycle with div_start=0.
- Overflow 0x80000000 / -1 (signed) wraps: quotient 0x80000000, remainder 0; no trap.
- Magnitude of 0x80000000 is 0x80000000 treated as unsigned.

Decomposition:
- Shared package: state encoding (IDLE/BYZERO/BUSY/DONE), DW, CNT_W, divider-result width macro (alongside the existing bus-width defines).
- Sub-module div_restore_step: combinational single iteration (rem_in, dvd_msb, divisor) -> (rem_out, q_bit); instantiated once; the FSM/datapath stays in ex_div_unit.

Test Plan:
1. Unsigned 100/7, start held:
   - stallreq=1 for 33 cycles.
   - div_ready rises after 33 edges, div_result={32'd2, 32'd14}.
   - Drop start -> next edge ready=0, result=0.
2. Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
   - Also 7/-2 -> q 0xFFFFFFFD, r 0x00000001.
3. Divide by zero 5/0 -> ready after 2 edges, div_result=64'h0.
4. Signed 0x80000000/0xFFFFFFFF -> q 0x80000000, r 0.
   - Unsigned 0xFFFFFFFF/0x00000001 -> q 0xFFFFFFFF, r 0.
5. Annul on 10th BUSY cycle:
   - Next edge IDLE, ready=0, result=0.
   - Fresh 9/3 accepted next cycle -> {0, 3} after 33 edges.
   - Operands changed mid-BUSY -> result unaffected.
6. Async reset pulse mid-BUSY between clock edges:
   - Outputs 0 immediately.
   - After release with start held, a new divide runs to its normal result.
